instruction_issuer: RTL and testbench

Drives the core's instruction interface from a host-loaded queue: accepts 32-bit instructions into a FIFO, presents each one to the core with `validInstruction`, holds it until `completeInstruction`, then inserts a mandatory one-cycle release gap before the next issue. It is the initiator end of the core's valid/complete instruction handshake and replaces the testbench stimulus in the FPGA top level. It also tracks issue counts, stall cycles, and a completion timeout.

---
 rtl/instruction_issuer_pkg.sv | 16 +
 rtl/instruction_issuer_if.sv | 34 +++
 rtl/instruction_issuer_fifo.sv | 44 ++++
 rtl/instruction_issuer.sv | 93 +++++++++
 tb/tb_instruction_issuer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_issuer_pkg.sv
// issuer_pkg: shared types and constants for the instruction issuer.
// Imported by the interface, FIFO and top.
package issuer_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        ERROR   = 2'd3
    } state_e;

endpackage

// File: rtl/instruction_issuer_if.sv
// instruction_issuer_if: host load port, core valid/complete handshake
// and status outputs of the instruction issuer.
interface instruction_issuer_if #(
    parameter int DEPTH = 16
) ();
    import issuer_pkg::*;

    logic [INSTR_W-1:0]      loadInstruction;
    logic                    loadValid;
    logic                    loadReady;
    logic                    start;
    logic [INSTR_W-1:0]      instruction;
    logic                    validInstruction;
    logic                    completeInstruction;
    logic                    busy;
    logic                    done;
    logic                    timeoutError;
    logic [$clog2(DEPTH):0]  fifoCount;
    logic [31:0]             issuedCount;
    logic [31:0]             stallCycles;

    modport master (
        input  loadInstruction, loadValid, start, completeInstruction,
        output loadReady, instruction, validInstruction, busy, done,
        output timeoutError, fifoCount, issuedCount, stallCycles
    );

    modport slave (
        output loadInstruction, loadValid, start, completeInstruction,
        input  loadReady, instruction, validInstruction, busy, done,
        input  timeoutError, fifoCount, issuedCount, stallCycles
    );

endinterface

// File: rtl/instruction_issuer_fifo.sv
// issue_fifo: synchronous DEPTH x INSTR_W FIFO with extra-bit pointers
// so full and empty are distinguished without a separate counter.
module issue_fifo
    import issuer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [INSTR_W-1:0]      push_data,
    input  logic                    pop,
    output logic [INSTR_W-1:0]      head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_q;
    logic [AW:0]        rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/instruction_issuer.sv
// instruction_issuer: queue-fed initiator of the core's valid/complete
// instruction handshake, with completion watchdog and issue statistics.
module instruction_issuer
    import issuer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  reset,
    instruction_issuer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] head;
    logic               valid_q, busy_q, done_q, err_q;
    logic [31:0]        issued_q, stall_q;
    logic [WW-1:0]      wd_q;
    logic [AW:0]        count;
    logic               full, empty, push, pop;

    // A stale completion outside ISSUE must never pop the queue.
    assign pop  = (state_q == ISSUE) && bus.completeInstruction;
    assign push = bus.loadValid && bus.loadReady;
    assign bus.loadReady = !full || pop;

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.loadInstruction),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start && !empty) state_d = ISSUE;
            ISSUE: begin
                if (pop)                  state_d = RELEASE;
                else if (wd_q == WD_LAST) state_d = ERROR;
            end
            RELEASE: state_d = empty ? IDLE : ISSUE;
            ERROR:   if (bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are loaded from the next state so they all change on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ISSUE);
            instr_q <= (state_d == ISSUE) ? head : '0;
            busy_q  <= (state_d == ISSUE) || (state_d == RELEASE);
            done_q  <= (state_q == RELEASE) && empty;
            err_q   <= (state_d == ERROR);
            wd_q    <= (state_q == ISSUE) ? wd_q + WW'(1) : '0;
            if (pop)              issued_q <= issued_q + 32'd1;
            if (state_q == ISSUE) stall_q  <= stall_q + 32'd1;
        end
    end

    assign bus.instruction      = instr_q;
    assign bus.validInstruction = valid_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.timeoutError     = err_q;
    assign bus.fifoCount        = count;
    assign bus.issuedCount      = issued_q;
    assign bus.stallCycles      = stall_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// tb_instruction_issuer: directed stimulus with a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_instruction_issuer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_GAP   = 2;
    localparam int P_ERR   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        st = 1'b0;
    logic        man_cmp = 1'b0;
    logic        auto_cmp = 1'b0;
    logic        auto_core = 1'b0;
    logic        prev_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    // reference model
    logic [31:0] m_q[$];
    int          m_ph = P_IDLE;
    int          m_age = 0;
    logic [31:0] m_issued = '0;
    logic [31:0] m_stall = '0;
    logic        m_done = 1'b0;

    // observation log for literal checks
    logic [31:0] log_q[$];
    int          done_cnt = 0;
    int          vcyc = 0;
    logic        mon_prev = 1'b0;

    instruction_issuer_if #(.DEPTH(DEPTH)) bus ();

    assign bus.loadInstruction     = ld_data;
    assign bus.loadValid           = ld_valid;
    assign bus.start               = st;
    assign bus.completeInstruction = auto_core ? auto_cmp : man_cmp;

    instruction_issuer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ph = P_IDLE;
        m_age = 0;
        m_issued = '0;
        m_stall = '0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        bit pop, push;
        pop  = (m_ph == P_ISSUE) && (bus.completeInstruction === 1'b1);
        push = (bus.loadValid === 1'b1) && (m_q.size() < DEPTH || pop);
        m_done = (m_ph == P_GAP) && (m_q.size() == 0);
        case (m_ph)
            P_IDLE: if (bus.start && m_q.size() > 0) begin
                m_ph = P_ISSUE;
                m_age = 0;
            end
            P_ISSUE: begin
                m_stall++;
                m_age++;
                if (pop) begin
                    m_q.delete(0);
                    m_issued++;
                    m_ph = P_GAP;
                end else if (m_age == TIMEOUT) begin
                    m_ph = P_ERR;
                end
            end
            P_GAP: begin
                if (m_q.size() > 0) begin
                    m_ph = P_ISSUE;
                    m_age = 0;
                end else begin
                    m_ph = P_IDLE;
                end
            end
            default: if (bus.start) m_ph = P_IDLE;
        endcase
        if (push) m_q.push_back(bus.loadInstruction);
    endtask

    task automatic compare();
        logic        ev;
        logic [31:0] ei;
        logic        er;
        ev = (m_ph == P_ISSUE);
        ei = ev ? m_q[0] : 32'h0;
        er = (m_q.size() < DEPTH) ||
             (m_ph == P_ISSUE && bus.completeInstruction === 1'b1);
        chk("validInstruction", 32'(bus.validInstruction), 32'(ev));
        chk("instruction", bus.instruction, ei);
        chk("busy", 32'(bus.busy), 32'(m_ph == P_ISSUE || m_ph == P_GAP));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("timeoutError", 32'(bus.timeoutError), 32'(m_ph == P_ERR));
        chk("fifoCount", 32'(bus.fifoCount), 32'(m_q.size()));
        chk("loadReady", 32'(bus.loadReady), 32'(er));
        chk("issuedCount", bus.issuedCount, m_issued);
        chk("stallCycles", bus.stallCycles, m_stall);
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #2;
        compare();
        if (bus.validInstruction && !mon_prev) log_q.push_back(bus.instruction);
        mon_prev = bus.validInstruction;
        if (bus.done) done_cnt++;
        if (bus.validInstruction) vcyc++;
    end

    // Core model: completes in the second cycle an instruction is valid.
    always @(posedge clk) begin
        #1;
        auto_cmp = bus.validInstruction && prev_valid;
        prev_valid = bus.validInstruction;
    end

    task automatic do_reset();
        auto_core = 1'b0;
        man_cmp = 1'b0;
        ld_valid = 1'b0;
        st = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        done_cnt = 0;
        vcyc = 0;
    endtask

    task automatic load(input logic [31:0] d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!bus.done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] five[5];
        int n;
        five = '{32'h000000B3, 32'h40000133, 32'h000071B3,
                 32'h00006233, 32'h000042B3};

        // reset state
        do_reset();
        chk("rst_valid", 32'(bus.validInstruction), 32'd0);
        chk("rst_instr", bus.instruction, 32'd0);
        chk("rst_loadReady", 32'(bus.loadReady), 32'd1);
        chk("rst_count", 32'(bus.fifoCount), 32'd0);
        chk("rst_err", 32'(bus.timeoutError), 32'd0);

        // single instruction
        auto_core = 1'b1;
        load(32'h000000B3);
        pulse_start();
        wait_done(20);
        chk("t1_issued", bus.issuedCount, 32'd1);
        chk("t1_stall", bus.stallCycles, 32'd2);
        chk("t1_vcyc", 32'(vcyc), 32'd2);
        chk("t1_log0", log_q[0], 32'h000000B3);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // five in order
        do_reset();
        for (int i = 0; i < 5; i++) load(five[i]);
        auto_core = 1'b1;
        pulse_start();
        wait_done(60);
        chk("t2_issued", bus.issuedCount, 32'd5);
        chk("t2_stall", bus.stallCycles, 32'd10);
        chk("t2_vcyc", 32'(vcyc), 32'd10);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_log_n", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            chk("t2_log", log_q[i], five[i]);

        // timeout then retry of the same head
        do_reset();
        load(32'h000000B3);
        load(32'h40000133);
        pulse_start();
        n = 0;
        while (!bus.timeoutError && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t3_err_seen", 32'(bus.timeoutError), 32'd1);
        chk("t3_stall", bus.stallCycles, 32'd8);
        chk("t3_count", 32'(bus.fifoCount), 32'd2);
        chk("t3_issued", bus.issuedCount, 32'd0);
        pulse_start();
        chk("t3_err_clr", 32'(bus.timeoutError), 32'd0);
        chk("t3_idle", 32'(bus.busy), 32'd0);
        auto_core = 1'b1;
        pulse_start();
        wait_done(40);
        chk("t3_log_n", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("t3_retry", log_q[1], 32'h000000B3);
            chk("t3_next", log_q[2], 32'h40000133);
        end
        chk("t3_issued2", bus.issuedCount, 32'd2);
        chk("t3_stall2", bus.stallCycles, 32'd12);

        // full FIFO, dropped load, load during pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data = 32'h100 + 32'(i);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        chk("t4_full_ready", 32'(bus.loadReady), 32'd0);
        chk("t4_full_count", 32'(bus.fifoCount), 32'd16);
        load(32'h0000DEAD);
        chk("t4_drop_count", 32'(bus.fifoCount), 32'd16);
        pulse_start();
        man_cmp = 1'b1;
        ld_valid = 1'b1;
        ld_data = 32'h00000ABC;
        #1;
        chk("t4_pop_ready", 32'(bus.loadReady), 32'd1);
        @(negedge clk);
        man_cmp = 1'b0;
        ld_valid = 1'b0;
        chk("t4_pop_count", 32'(bus.fifoCount), 32'd16);
        auto_core = 1'b1;
        wait_done(120);
        chk("t4_issued", bus.issuedCount, 32'd17);
        chk("t4_log_n", 32'(log_q.size()), 32'd17);
        if (log_q.size() == 17) begin
            chk("t4_first", log_q[0], 32'h100);
            chk("t4_last", log_q[16], 32'h00000ABC);
        end

        // stray completions and start while busy
        do_reset();
        load(32'h0000000A);
        load(32'h0000000B);
        @(negedge clk);
        man_cmp = 1'b1;
        @(negedge clk);
        man_cmp = 1'b0;
        chk("t5_idle_cnt", 32'(bus.fifoCount), 32'd2);
        chk("t5_idle_iss", bus.issuedCount, 32'd0);
        pulse_start();
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        man_cmp = 1'b1;
        @(negedge clk);
        chk("t5_release", 32'(bus.validInstruction), 32'd0);
        @(negedge clk);
        man_cmp = 1'b0;
        auto_core = 1'b1;
        chk("t5_rel_iss", bus.issuedCount, 32'd1);
        chk("t5_rel_cnt", 32'(bus.fifoCount), 32'd1);
        wait_done(20);
        chk("t5_issued", bus.issuedCount, 32'd2);
        chk("t5_stall", bus.stallCycles, 32'd4);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);

        // asynchronous reset in ISSUE
        do_reset();
        for (int i = 0; i < 3; i++) load(32'h00000100 + 32'(i));
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t6_pre_valid", 32'(bus.validInstruction), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.validInstruction), 32'd0);
        chk("t6_count", 32'(bus.fifoCount), 32'd0);
        chk("t6_stall", bus.stallCycles, 32'd0);
        chk("t6_issued", bus.issuedCount, 32'd0);
        chk("t6_ready", 32'(bus.loadReady), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
